glb_tile_evt_pipe: RTL and testbench

- Parametrised event and timing pipeline for a GLB tile, sitting between tile-level control (start triggers, clk_en) and glb_core.
- Retimes start pulses and clk_en into the core by a configurable number of stages.
- Retimes per-channel done pulses out of the core into interrupt pulses.
- Adds sticky, maskable, write-1-to-clear interrupt status with saturating per-channel event counters and an aggregated level interrupt.

---
 rtl/glb_tile_evt_pipe_pkg.sv | 11 +
 rtl/glb_tile_evt_pipe_pulse_shift.sv | 30 +++
 rtl/glb_tile_evt_pipe.sv | 70 +++++++
 tb/tb_glb_tile_evt_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_tile_evt_pipe_pkg.sv
// global_buffer_param: shared GLB tile defaults and channel numbering.
package global_buffer_param;
  localparam int NUM_START = 2;
  localparam int NUM_CH    = 3;
  localparam int CNT_WIDTH = 8;
  typedef enum logic [1:0] {
    CH_STRM_F2G = 2'd0,
    CH_STRM_G2F = 2'd1,
    CH_PCFG     = 2'd2
  } glb_ch_e;
endpackage

// File: rtl/glb_tile_evt_pipe_pulse_shift.sv
// glb_pulse_shift: DEPTH-stage retiming chain with async reset and sync clear.
module glb_pulse_shift #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, clr_i};
    assign q_o = d_i;
  end else begin : g_chain
    logic [WIDTH-1:0] stage_q [DEPTH];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else if (clr_i) begin
        for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
      end
    end
    assign q_o = stage_q[DEPTH-1];
  end
endmodule

// File: rtl/glb_tile_evt_pipe.sv
// glb_tile_evt_pipe: retimes start/clk_en into glb_core and done pulses out as
// interrupts, with sticky W1C status, saturating event counters and a level irq.
module glb_tile_evt_pipe #(
  parameter int NUM_START   = global_buffer_param::NUM_START,
  parameter int NUM_CH      = global_buffer_param::NUM_CH,
  parameter int START_DEPTH = 1,
  parameter int IRQ_DEPTH   = 1,
  parameter int CNT_WIDTH   = global_buffer_param::CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        soft_reset,
  input  logic                        clk_en,
  output logic                        clk_en_core,
  input  logic [NUM_START-1:0]        start_pulse,
  output logic [NUM_START-1:0]        start_pulse_core,
  input  logic [NUM_CH-1:0]           done_pulse_core,
  input  logic [NUM_CH-1:0]           irq_mask,
  input  logic [NUM_CH-1:0]           irq_clear,
  output logic [NUM_CH-1:0]           irq_pulse,
  output logic [NUM_CH-1:0]           irq_status,
  output logic [NUM_CH*CNT_WIDTH-1:0] irq_count,
  output logic                        irq_level
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  glb_pulse_shift #(.WIDTH(NUM_START + 1), .DEPTH(START_DEPTH)) u_start_shift (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (soft_reset),
    .d_i    ({clk_en, start_pulse}),
    .q_o    ({clk_en_core, start_pulse_core})
  );

  // The mask is applied before the chain so pulses already in flight are unaffected.
  glb_pulse_shift #(.WIDTH(NUM_CH), .DEPTH(IRQ_DEPTH)) u_irq_shift (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (soft_reset),
    .d_i    (done_pulse_core & ~irq_mask),
    .q_o    (irq_pulse)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic                 st_q, st_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // A clear coinciding with a new event keeps that event: status stays set, count restarts at 1.
    always_comb begin
      st_d  = done_pulse_core[i] | (st_q & ~irq_clear[i]);
      cnt_d = irq_clear[i] ? CNT_WIDTH'(done_pulse_core[i])
            : (done_pulse_core[i] && cnt_q != CNT_MAX) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q  <= 1'b0;
        cnt_q <= '0;
      end else if (soft_reset) begin
        st_q  <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end
    assign irq_status[i] = st_q;
    assign irq_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
  end

  assign irq_level = |(irq_status & ~irq_mask);
endmodule

// File: tb/tb_glb_tile_evt_pipe.sv
// tb_glb_tile_evt_pipe: checks a retiming instance (depths 2/1) and a pass-through
// instance (depths 0/0) against a delay-line and event-count reference model.
module tb_glb_tile_evt_pipe;
  import global_buffer_param::*;
  localparam int SD   = 2;
  localparam int ID   = 1;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0, reset = 1'b0, soft_reset = 1'b0, clk_en = 1'b0;
  logic [1:0] start_pulse = '0;
  logic [2:0] done = '0, mask = '0, clr = '0;
  logic clk_en_core, irq_level, clk_en_core_z, irq_level_z;
  logic [1:0] spc, spc_z;
  logic [2:0] ip, ip_z, st, st_z;
  logic [11:0] cnt, cnt_z;
  logic [21:0] act, act_z;
  int n_checks = 0, n_fail = 0;

  logic [2:0] sq[$];
  logic [2:0] iq[$];
  logic [2:0] mst;
  int mcnt[3];

  glb_tile_evt_pipe #(.NUM_START(2), .NUM_CH(3), .START_DEPTH(SD), .IRQ_DEPTH(ID), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .clk_en(clk_en), .clk_en_core(clk_en_core),
    .start_pulse(start_pulse), .start_pulse_core(spc), .done_pulse_core(done), .irq_mask(mask),
    .irq_clear(clr), .irq_pulse(ip), .irq_status(st), .irq_count(cnt), .irq_level(irq_level)
  );

  glb_tile_evt_pipe #(.NUM_START(2), .NUM_CH(3), .START_DEPTH(0), .IRQ_DEPTH(0), .CNT_WIDTH(CW)) dut_z (
    .clk(clk), .reset(reset), .soft_reset(soft_reset), .clk_en(clk_en), .clk_en_core(clk_en_core_z),
    .start_pulse(start_pulse), .start_pulse_core(spc_z), .done_pulse_core(done), .irq_mask(mask),
    .irq_clear(clr), .irq_pulse(ip_z), .irq_status(st_z), .irq_count(cnt_z), .irq_level(irq_level_z)
  );

  assign act   = {clk_en_core, spc, ip, st, cnt, irq_level};
  assign act_z = {clk_en_core_z, spc_z, ip_z, st_z, cnt_z, irq_level_z};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout act=%h", act);
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] mcnt_vec();
    logic [11:0] v;
    for (int i = 0; i < 3; i++) v[i*4 +: 4] = 4'(mcnt[i]);
    return v;
  endfunction

  function automatic logic [21:0] exp_vec();
    return {sq[0], iq[0], mst, mcnt_vec(), |(mst & ~mask)};
  endfunction

  function automatic logic [21:0] exp_vec_z();
    return {clk_en, start_pulse, done & ~mask, mst, mcnt_vec(), |(mst & ~mask)};
  endfunction

  task automatic model_clear();
    sq.delete();
    iq.delete();
    repeat (SD) sq.push_back('0);
    repeat (ID) iq.push_back('0);
    mst = '0;
    for (int i = 0; i < 3; i++) mcnt[i] = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset || soft_reset) model_clear();
    else begin
      sq.push_back({clk_en, start_pulse});
      void'(sq.pop_front());
      iq.push_back(done & ~mask);
      void'(iq.pop_front());
      for (int i = 0; i < 3; i++) begin
        if (clr[i]) mcnt[i] = done[i] ? 1 : 0;
        else if (done[i]) mcnt[i] = (mcnt[i] == CMAX) ? CMAX : mcnt[i] + 1;
        if (done[i]) mst[i] = 1'b1;
        else if (clr[i]) mst[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle();
    start_pulse = '0; done = '0; clr = '0; soft_reset = 1'b0;
  endtask

  task automatic soft_clear();
    idle(); mask = '0; clk_en = 1'b0; soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    #3;
    n_checks++;
    if (act !== 22'd0) begin n_fail++; $display("FAIL reset_state act=%h exp=%h", act, 22'd0); end
    n_checks++;
    if (act_z !== 22'd0) begin n_fail++; $display("FAIL reset_state_z act=%h exp=%h", act_z, 22'd0); end
    @(negedge clk) reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    soft_clear();
    start_pulse = 2'b01; done[CH_PCFG] = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (spc !== ((k == 1) ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL basic_start k=%0d act=%b exp=%b", k, spc, (k == 1) ? 2'b01 : 2'b00); end
      n_checks++;
      if (ip !== ((k == 0) ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL basic_irq k=%0d act=%b exp=%b", k, ip, (k == 0) ? 3'b100 : 3'b000); end
      n_checks++;
      if ({st, cnt[8 +: 4], irq_level} !== {3'b100, 4'd1, 1'b1}) begin n_fail++; $display("FAIL basic_status k=%0d st=%b cnt=%0d lvl=%b", k, st, cnt[8 +: 4], irq_level); end
      n_checks++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL basic_model k=%0d act=%h exp=%h", k, act, exp_vec()); end
      tick();
    end
  endtask

  task automatic test_mask();
    soft_clear();
    mask = 3'b010;
    repeat (3) begin
      done = 3'b010;
      tick();
      done = '0;
      n_checks++;
      if ({ip[1], irq_level} !== 2'b00) begin n_fail++; $display("FAIL mask_gate ip=%b lvl=%b exp=00", ip[1], irq_level); end
      tick();
      n_checks++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL mask_model act=%h exp=%h", act, exp_vec()); end
    end
    n_checks++;
    if ({st[1], cnt[4 +: 4]} !== {1'b1, 4'd3}) begin n_fail++; $display("FAIL mask_count st=%b cnt=%0d exp=1/3", st[1], cnt[4 +: 4]); end
    mask = '0;
    #1;
    n_checks++;
    if (irq_level !== 1'b1) begin n_fail++; $display("FAIL mask_unmask_level act=%b exp=1", irq_level); end
  endtask

  task automatic test_saturation();
    soft_clear();
    repeat (20) begin
      done = 3'b001;
      tick();
      n_checks++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL sat_model act=%h exp=%h", act, exp_vec()); end
    end
    done = '0;
    tick();
    n_checks++;
    if ({st[0], cnt[3:0]} !== {1'b1, 4'd15}) begin n_fail++; $display("FAIL sat_hold st=%b cnt=%0d exp=1/15", st[0], cnt[3:0]); end
    clr = 3'b001;
    tick();
    clr = '0;
    n_checks++;
    if ({st[0], cnt[3:0]} !== {1'b0, 4'd0}) begin n_fail++; $display("FAIL sat_clear st=%b cnt=%0d exp=0/0", st[0], cnt[3:0]); end
  endtask

  task automatic test_set_clear();
    soft_clear();
    repeat (5) begin done = 3'b001; tick(); end
    done = '0;
    n_checks++;
    if (cnt[3:0] !== 4'd5) begin n_fail++; $display("FAIL setclr_pre cnt=%0d exp=5", cnt[3:0]); end
    done = 3'b001; clr = 3'b001;
    tick();
    idle();
    n_checks++;
    if ({st[0], cnt[3:0]} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL setclr st=%b cnt=%0d exp=1/1", st[0], cnt[3:0]); end
    n_checks++;
    if (act !== exp_vec()) begin n_fail++; $display("FAIL setclr_model act=%h exp=%h", act, exp_vec()); end
  endtask

  task automatic test_reset_midflight();
    soft_clear();
    done = 3'b111; start_pulse = 2'b11; clk_en = 1'b1;
    tick();
    idle(); clk_en = 1'b0;
    #3 reset = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if (act !== 22'd0) begin n_fail++; $display("FAIL rst_mid act=%h exp=%h", act, 22'd0); end
    tick(); tick();
    @(negedge clk) reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (act !== 22'd0 || ip !== 3'b000) begin n_fail++; $display("FAIL rst_after k=%0d act=%h exp=%h", k, act, 22'd0); end
    end
  endtask

  task automatic test_soft_reset();
    soft_clear();
    done = 3'b111; start_pulse = 2'b11; clk_en = 1'b1;
    tick();
    start_pulse = 2'b10; done = 3'b101; soft_reset = 1'b1;
    tick();
    idle(); clk_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (act !== 22'd0) begin n_fail++; $display("FAIL soft_rst k=%0d act=%h exp=%h", k, act, 22'd0); end
      tick();
    end
  endtask

  task automatic test_depth0();
    soft_clear();
    for (int k = 0; k < 12; k++) begin
      start_pulse = 2'($urandom); clk_en = 1'($urandom); done = 3'($urandom); mask = 3'($urandom);
      #1;
      n_checks++;
      if ({clk_en_core_z, spc_z, ip_z} !== {clk_en, start_pulse, done & ~mask}) begin
        n_fail++; $display("FAIL depth0_pass k=%0d act=%b exp=%b", k, {clk_en_core_z, spc_z, ip_z}, {clk_en, start_pulse, done & ~mask});
      end
      n_checks++;
      if (act_z !== exp_vec_z()) begin n_fail++; $display("FAIL depth0_model k=%0d act=%h exp=%h", k, act_z, exp_vec_z()); end
      tick();
    end
    idle(); clk_en = 1'b0; mask = '0;
  endtask

  task automatic test_random();
    soft_clear();
    for (int k = 0; k < 400; k++) begin
      start_pulse = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      done        = 3'($urandom) & 3'($urandom);
      clr         = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      clk_en      = ($urandom_range(0, 7) == 0) ? ~clk_en : clk_en;
      if ($urandom_range(0, 9) == 0) mask = 3'($urandom);
      soft_reset  = ($urandom_range(0, 60) == 0);
      #1;
      n_checks++;
      if (act_z !== exp_vec_z()) begin n_fail++; $display("FAIL rand_z k=%0d act=%h exp=%h", k, act_z, exp_vec_z()); end
      tick();
      n_checks++;
      if (act !== exp_vec()) begin n_fail++; $display("FAIL rand k=%0d act=%h exp=%h", k, act, exp_vec()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_saturation();
    test_set_clear();
    test_reset_midflight();
    test_soft_reset();
    test_depth0();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
